axi_wdata_resp_slave: RTL and testbench
=======================================

Name: axi_wdata_resp_slave

Overview:
- Parametrised slave-side AXI write data and write response manager.
- Accepts one write burst per granted request and buffers up to MAX_BURST beats, zero-filling unused slots.
- Hands the assembled line to the backend, then returns the write response with the request ID once the backend reports commit.
- Successor to the fixed 4-beat, 32-bit write data manager; adds ID tracking, response handshake, overflow detection and a parametrised width and depth.

Parameters:
DATA_W, 32, width of wdata and of each buffer slot
ID_W, 32, width of req_id, wd_id and bid
MAX_BURST, 4, buffer depth in beats; power of two, 2..16
CNT_W, $clog2(MAX_BURST), width of the beat counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid  in  1  address phase granted; start a data phase
req_ready  out  1  high only in IDLE
req_id  in  ID_W  ID of the granted request
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_W  write data beat
wlast  in  1  last beat of the burst
wd_valid  out  1  assembled line valid; held until wd_ready
wd_ready  in  1  backend accepts the line
wd_data  out  DATA_W*MAX_BURST  slot k at bits [k*DATA_W +: DATA_W]
wd_beats  out  CNT_W+1  number of stored beats, 1..MAX_BURST
wd_id  out  ID_W  latched request ID
finish_wd  in  1  backend commit pulse for the outstanding line
bvalid  out  1  write response valid
bready  in  1  master accepts the response
bid  out  ID_W  equals the latched ID
bresp  out  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset (rst high at a clk edge):
  - state goes to IDLE; beat counter clears; buffer clears to 0.
  - wready, wd_valid and bvalid are 0; req_ready is 1; bresp, bid and wd_id are 0.
- Reset mid-burst aborts with no response and no handoff.
- States:
  - IDLE: req_valid → DATA. Latch req_id, clear the counter, clear all slots, clear the error flag.
  - DATA: wready=1. A beat transfers when wvalid & wready.
    - Beat with counter < MAX_BURST: store into slot[counter], counter+1.
    - Beat with counter == MAX_BURST: discard it and set the error flag.
    - A transfer with wlast → HAND.
  - HAND: wready=0, wd_valid=1. wd_valid & wd_ready → WAIT.
  - WAIT: on finish_wd → RESP.
  - RESP: bvalid=1. bvalid & bready → IDLE.
- Output timing:
  - wd_valid rises the cycle after the wlast transfer.
  - bvalid rises the cycle after finish_wd.
  - No combinational path from any input to wready, wd_valid or bvalid.
- wd_beats equals the counter value at wlast, saturated at MAX_BURST.
- Slots at or above wd_beats read 0.
- bresp is 2'b10 if the error flag is set, else 2'b00.
- finish_wd outside WAIT is ignored.
- req_valid outside IDLE is ignored; the master holds it until req_ready.
- wvalid outside DATA is not accepted.
- Back-to-back bursts: bvalid & bready & req_valid in the same cycle go to IDLE only. The next request is taken one cycle later, giving a minimum 1 idle cycle between bursts.
- wd_data, wd_id and wd_beats stay stable from HAND through RESP.

Optional Feature:
- Macro WSTRB_EN.
- Defined:
  - Adds input wstrb [DATA_W/8] and output wd_strb [DATA_W/8*MAX_BURST].
  - Strobes are stored per slot alongside data; unfilled slots and discarded beats give strobe 0.
- Undefined:
  - No strobe ports; the backend treats every stored byte as enabled.

Test Plan:
- 4-beat burst, MAX_BURST=4, req_id=0x5A, wdata 0x11,0x22,0x33,0x44, wd_ready=1, finish_wd 2 cycles after handoff, bready=1 → wd_data={0x44,0x33,0x22,0x11}, wd_beats=4, bid=0x5A, bresp=00; bvalid 1 cycle after finish_wd.
- 2-beat burst 0xAA,0xBB after a prior full burst → slots 2,3 read 0, wd_beats=2, bresp=00.
- 6-beat burst with wlast on beat 6, MAX_BURST=4 → all 6 beats accepted, slots hold beats 1-4, bresp=10, wd_beats=4.
- wvalid toggling 1/0 and wd_ready held low 5 cycles → no beat lost; wd_valid held stable 5 cycles with constant data.
- bready low 3 cycles with req_valid high throughout → bvalid and bid held; req_ready=0 until 1 cycle after bvalid&bready; second ID latched afterwards.
- rst asserted on beat 2 of 4 → next cycle wready=0, bvalid=0, wd_valid=0, req_ready=1; a new burst completes normally.

Source files
------------

// File: rtl/axi_wdata_resp_slave.sv
// Slave-side AXI write data collector and write response generator.
// Optional byte strobes are enabled by defining WSTRB_EN.
module axi_wdata_resp_slave #(
  parameter int DATA_W    = 32,
  parameter int ID_W      = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ID_W-1:0]             req_id,
  input  logic                        wvalid,
  output logic                        wready,
  input  logic [DATA_W-1:0]           wdata,
  input  logic                        wlast,
`ifdef WSTRB_EN
  input  logic [DATA_W/8-1:0]         wstrb,
  output logic [DATA_W/8*MAX_BURST-1:0] wd_strb,
`endif
  output logic                        wd_valid,
  input  logic                        wd_ready,
  output logic [DATA_W*MAX_BURST-1:0] wd_data,
  output logic [CNT_W:0]              wd_beats,
  output logic [ID_W-1:0]             wd_id,
  input  logic                        finish_wd,
  output logic                        bvalid,
  input  logic                        bready,
  output logic [ID_W-1:0]             bid,
  output logic [1:0]                  bresp
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_HAND, S_WAIT, S_RESP} state_e;

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_BURST);

  state_e            state_q;
  logic [CNT_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] slot_q [MAX_BURST];
`ifdef WSTRB_EN
  logic [DATA_W/8-1:0] strb_q [MAX_BURST];
`endif
  logic [ID_W-1:0]   id_q;
  logic              err_q;
  logic              req_ready_q, wready_q, wd_valid_q, bvalid_q;

  logic beat_fire, room;

  assign beat_fire = wvalid & wready_q;
  assign room      = (cnt_q != MAX_CNT);
  assign cnt_d     = cnt_q + (CNT_W+1)'(1);

  // NOTE: all state below is registered with non-blocking assignments so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      wready_q    <= 1'b0;
      wd_valid_q  <= 1'b0;
      bvalid_q    <= 1'b0;
      // NOTE: the line buffer is reset explicitly because its contents are
      // visible on wd_data and must read zero after reset.
      for (int k = 0; k < MAX_BURST; k++) begin
        slot_q[k] <= '0;
`ifdef WSTRB_EN
        strb_q[k] <= '0;
`endif
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q     <= S_DATA;
            id_q        <= req_id;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            wready_q    <= 1'b1;
            for (int k = 0; k < MAX_BURST; k++) begin
              slot_q[k] <= '0;
`ifdef WSTRB_EN
              strb_q[k] <= '0;
`endif
            end
          end
        end
        S_DATA: begin
          if (beat_fire) begin
            // Beats past the buffer depth are swallowed and flagged as SLVERR.
            if (room) begin
              slot_q[cnt_q[CNT_W-1:0]] <= wdata;
`ifdef WSTRB_EN
              strb_q[cnt_q[CNT_W-1:0]] <= wstrb;
`endif
              cnt_q <= cnt_d;
            end else begin
              err_q <= 1'b1;
            end
            if (wlast) begin
              state_q    <= S_HAND;
              wready_q   <= 1'b0;
              wd_valid_q <= 1'b1;
            end
          end
        end
        S_HAND: begin
          if (wd_ready) begin
            state_q    <= S_WAIT;
            wd_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (finish_wd) begin
            state_q  <= S_RESP;
            bvalid_q <= 1'b1;
          end
        end
        S_RESP: begin
          // Returning through IDLE enforces one idle cycle between bursts.
          if (bready) begin
            state_q     <= S_IDLE;
            bvalid_q    <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_data = '0;
    for (int k = 0; k < MAX_BURST; k++) begin
      wd_data[k*DATA_W +: DATA_W] = slot_q[k];
    end
  end

`ifdef WSTRB_EN
  always_comb begin
    wd_strb = '0;
    for (int k = 0; k < MAX_BURST; k++) begin
      wd_strb[k*(DATA_W/8) +: DATA_W/8] = strb_q[k];
    end
  end
`endif

  assign req_ready = req_ready_q;
  assign wready    = wready_q;
  assign wd_valid  = wd_valid_q;
  assign bvalid    = bvalid_q;
  assign wd_beats  = cnt_q;
  assign wd_id     = id_q;
  assign bid       = id_q;
  assign bresp     = {err_q, 1'b0};

endmodule

// File: tb/tb_axi_wdata_resp_slave.sv
// Bench for axi_wdata_resp_slave: table of bursts plus hand-written corner
// sequences; line and response expectations are checked through a scoreboard.
module tb_axi_wdata_resp_slave;

  localparam int DATA_W    = 32;
  localparam int ID_W      = 32;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 2;
  localparam int LINE_W    = DATA_W * MAX_BURST;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [ID_W-1:0]     req_id = '0;
  logic                wvalid = 1'b0;
  logic                wready;
  logic [DATA_W-1:0]   wdata = '0;
  logic                wlast = 1'b0;
  logic                wd_valid;
  logic                wd_ready = 1'b0;
  logic [LINE_W-1:0]   wd_data;
  logic [CNT_W:0]      wd_beats;
  logic [ID_W-1:0]     wd_id;
  logic                finish_wd = 1'b0;
  logic                bvalid;
  logic                bready = 1'b0;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
`ifdef WSTRB_EN
  logic [DATA_W/8-1:0]           wstrb = '1;
  logic [DATA_W/8*MAX_BURST-1:0] wd_strb;
`endif

  always #5 clk = ~clk;

  axi_wdata_resp_slave #(
    .DATA_W(DATA_W), .ID_W(ID_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
`ifdef WSTRB_EN
    .wstrb(wstrb), .wd_strb(wd_strb),
`endif
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .wd_beats(wd_beats), .wd_id(wd_id), .finish_wd(finish_wd),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  typedef struct {
    logic [ID_W-1:0]              id;
    int                           n;
    bit                           toggle;
    int                           wd_hold;
    int                           fin_delay;
    int                           b_hold;
    logic [7:0][DATA_W-1:0]       data;
    int                           exp_beats;
    logic [1:0]                   exp_resp;
  } vec_t;

  typedef struct {
    logic [LINE_W-1:0] line;
    logic [CNT_W:0]    beats;
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t line_q[$];
  exp_t resp_q[$];
  exp_t mon_e;
  vec_t vecs[6];

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [ID_W-1:0] id, input int n,
                              input bit tog, input int hold, input int fin,
                              input int bh, input logic [7:0][DATA_W-1:0] d,
                              input int eb, input logic [1:0] er);
    vec_t v;
    v.id = id; v.n = n; v.toggle = tog; v.wd_hold = hold;
    v.fin_delay = fin; v.b_hold = bh; v.data = d;
    v.exp_beats = eb; v.exp_resp = er;
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.line = '0;
    for (int k = 0; k < v.exp_beats; k++) e.line[k*DATA_W +: DATA_W] = v.data[k];
    e.beats = (CNT_W+1)'(v.exp_beats);
    e.id    = v.id;
    e.resp  = v.exp_resp;
    return e;
  endfunction

  // Scoreboard: pop an expectation whenever a handshake is about to complete.
  always @(negedge clk) begin
    if (!rst && wd_valid && wd_ready) begin
      if (line_q.size() == 0) timeout("line_sb_unexpected");
      else begin
        mon_e = line_q.pop_front();
        check("sb_wd_data", wd_data, mon_e.line);
        check("sb_wd_beats", LINE_W'(wd_beats), LINE_W'(mon_e.beats));
        check("sb_wd_id", LINE_W'(wd_id), LINE_W'(mon_e.id));
      end
    end
    if (!rst && bvalid && bready) begin
      if (resp_q.size() == 0) timeout("resp_sb_unexpected");
      else begin
        mon_e = resp_q.pop_front();
        check("sb_bid", LINE_W'(bid), LINE_W'(mon_e.id));
        check("sb_bresp", LINE_W'(bresp), LINE_W'(mon_e.resp));
      end
    end
  end

  task automatic do_request(input logic [ID_W-1:0] id);
    int t = 0;
    req_valid = 1'b1;
    req_id    = id;
    while (!req_ready && t < 100) begin step(); t++; end
    if (t >= 100) timeout("req_ready_wait");
    step();
    req_valid = 1'b0;
    check("req_accept_wready", LINE_W'(wready), LINE_W'(1));
  endtask

  task automatic do_beats(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      int t = 0;
      if (v.toggle) begin
        wvalid = 1'b0;
        step();
      end
      wvalid = 1'b1;
      wdata  = v.data[i];
      wlast  = (i == v.n - 1);
      while (!wready && t < 100) begin step(); t++; end
      if (t >= 100) timeout("wready_wait");
      step();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("wd_valid_after_wlast", LINE_W'(wd_valid), LINE_W'(1));
    check("wready_low_in_hand", LINE_W'(wready), LINE_W'(0));
  endtask

  task automatic backend(input vec_t v, input exp_t e);
    logic [LINE_W-1:0] held;
    held = wd_data;
    for (int h = 0; h < v.wd_hold; h++) begin
      finish_wd = (h == 0);  // a commit pulse outside WAIT must be ignored
      step();
      finish_wd = 1'b0;
      check("wd_valid_held", LINE_W'(wd_valid), LINE_W'(1));
      check("wd_data_held", wd_data, held);
    end
    wd_ready = 1'b1;
    step();
    wd_ready = 1'b0;
    check("wd_valid_drop", LINE_W'(wd_valid), LINE_W'(0));
    for (int d = 0; d < v.fin_delay; d++) step();
    finish_wd = 1'b1;
    check("bvalid_before_finish", LINE_W'(bvalid), LINE_W'(0));
    step();
    finish_wd = 1'b0;
    check("bvalid_after_finish", LINE_W'(bvalid), LINE_W'(1));
    check("wd_data_stable_resp", wd_data, e.line);
    check("wd_beats_stable_resp", LINE_W'(wd_beats), LINE_W'(e.beats));
    check("wd_id_stable_resp", LINE_W'(wd_id), LINE_W'(e.id));
    for (int b = 0; b < v.b_hold; b++) begin
      step();
      check("bvalid_held", LINE_W'(bvalid), LINE_W'(1));
      check("bid_held", LINE_W'(bid), LINE_W'(e.id));
      check("req_ready_low_in_resp", LINE_W'(req_ready), LINE_W'(0));
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("bvalid_drop", LINE_W'(bvalid), LINE_W'(0));
    check("req_ready_after_b", LINE_W'(req_ready), LINE_W'(1));
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e = model(v);
    line_q.push_back(e);
    resp_q.push_back(e);
    do_request(v.id);
    do_beats(v);
    backend(v, e);
  endtask

  initial begin
    vec_t va, vb;
    exp_t ea, eb;

    vecs[0] = mk(32'h5A, 4, 0, 0, 2, 0,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h44, 32'h33, 32'h22, 32'h11}, 4, 2'b00);
    vecs[1] = mk(32'h3C, 2, 0, 0, 1, 0,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hBB, 32'hAA}, 2, 2'b00);
    vecs[2] = mk(32'h77, 6, 0, 0, 0, 1,
                 {32'h0, 32'h0, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 4, 2'b10);
    vecs[3] = mk(32'h0F, 3, 1, 5, 1, 0,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hC3, 32'hB2, 32'hA1}, 3, 2'b00);
    vecs[4] = mk(32'hDEAD_1234, 1, 0, 0, 3, 0,
                 {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, 1, 2'b00);
    vecs[5] = mk(32'h99, 5, 1, 0, 0, 0,
                 {32'h0, 32'h0, 32'h0, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11}, 4, 2'b10);

    // Reset state.
    rst = 1'b1;
    step();
    check("rst_req_ready", LINE_W'(req_ready), LINE_W'(1));
    check("rst_wready", LINE_W'(wready), LINE_W'(0));
    check("rst_wd_valid", LINE_W'(wd_valid), LINE_W'(0));
    check("rst_bvalid", LINE_W'(bvalid), LINE_W'(0));
    check("rst_bresp", LINE_W'(bresp), LINE_W'(0));
    check("rst_bid", LINE_W'(bid), LINE_W'(0));
    check("rst_wd_id", LINE_W'(wd_id), LINE_W'(0));
    check("rst_wd_beats", LINE_W'(wd_beats), LINE_W'(0));
    check("rst_wd_data", wd_data, '0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // bready held low with the next request already pending.
    va = mk(32'hA1, 3, 0, 0, 1, 3,
            {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3, 32'h2, 32'h1}, 3, 2'b00);
    vb = mk(32'hB2, 2, 0, 0, 1, 0,
            {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hE2, 32'hE1}, 2, 2'b00);
    ea = model(va);
    eb = model(vb);
    line_q.push_back(ea); resp_q.push_back(ea);
    line_q.push_back(eb); resp_q.push_back(eb);
    do_request(va.id);
    do_beats(va);
    req_valid = 1'b1;
    req_id    = vb.id;
    backend(va, ea);
    step();
    req_valid = 1'b0;
    check("b2b_second_accepted", LINE_W'(wready), LINE_W'(1));
    check("b2b_req_ready_low", LINE_W'(req_ready), LINE_W'(0));
    check("b2b_second_id", LINE_W'(wd_id), LINE_W'(vb.id));
    do_beats(vb);
    backend(vb, eb);

    // Reset on beat 2 of a 4-beat burst.
    do_request(32'h44);
    wvalid = 1'b1; wdata = 32'hF1; wlast = 1'b0;
    step();
    wdata = 32'hF2;
    rst   = 1'b1;
    step();
    rst    = 1'b0;
    wvalid = 1'b0;
    check("midrst_wready", LINE_W'(wready), LINE_W'(0));
    check("midrst_bvalid", LINE_W'(bvalid), LINE_W'(0));
    check("midrst_wd_valid", LINE_W'(wd_valid), LINE_W'(0));
    check("midrst_req_ready", LINE_W'(req_ready), LINE_W'(1));
    check("midrst_wd_data", wd_data, '0);
    check("midrst_wd_id", LINE_W'(wd_id), LINE_W'(0));
    step();
    check("midrst_no_handoff", LINE_W'(wd_valid), LINE_W'(0));
    run_vec(vecs[0]);

    repeat (3) step();
    check("sb_lines_drained", LINE_W'(line_q.size()), LINE_W'(0));
    check("sb_resps_drained", LINE_W'(resp_q.size()), LINE_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
